fc_layer2_argmax: RTL and testbench

Output stage of the classifier. Consumes the 8-element ReLU'd, saturated vector produced by the first fully-connected layer and computes NUM_CLASSES logits with a single time-multiplexed signed MAC. It saturates each logit to W bits and reports the index of the largest logit. It uses one multiplier instead of NUM_CLASSES×IN_SIZE, trading area for latency.

---
 rtl/fc_layer2_argmax.sv | 164 ++++++++++++++++
 tb/tb_fc_layer2_argmax.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fc_layer2_argmax.sv
// fc_layer2_argmax
//
// Second fully-connected layer plus argmax. A single signed multiplier is
// time-multiplexed over NUM_CLASSES x IN_SIZE steps. Each logit is saturated
// to W bits, and the index of the largest saturated logit is reported. On a
// tie, the lowest index wins.
//
// Ports:
//   clk             rising-edge clock
//   reset_n         asynchronous active-low reset
//   start           request; accepted only in IDLE or DONE
//   in_vector_flat  IN_SIZE signed activations, element k at [k*W +: W]
//   weights_flat    signed weights, (c,k) at [(c*IN_SIZE+k)*W +: W]; held while busy
//   biases_flat     signed biases, bias c at [c*W +: W]; held while busy
//   logits_flat     saturated logits, logit c at [c*W +: W]; valid while done
//   class_idx       index of the maximum logit
//   max_logit       value of the maximum logit
//   busy            high while the MAC sequence runs
//   done            level; results valid while high
module fc_layer2_argmax #(
  parameter int IN_SIZE     = 8,
  parameter int NUM_CLASSES = 10,
  parameter int W           = 8,
  parameter int ACC_WIDTH   = 2*W + $clog2(IN_SIZE) + 1,
  parameter int IDX_W       = $clog2(NUM_CLASSES)
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           start,
  input  logic [W*IN_SIZE-1:0]           in_vector_flat,
  input  logic [W*NUM_CLASSES*IN_SIZE-1:0] weights_flat,
  input  logic [W*NUM_CLASSES-1:0]       biases_flat,
  output logic [W*NUM_CLASSES-1:0]       logits_flat,
  output logic [IDX_W-1:0]               class_idx,
  output logic [W-1:0]                   max_logit,
  output logic                           busy,
  output logic                           done
);

  localparam int K_W = (IN_SIZE > 1) ? $clog2(IN_SIZE) : 1;
  localparam logic [K_W-1:0]   K_LAST = K_W'(IN_SIZE - 1);
  localparam logic [IDX_W-1:0] C_LAST = IDX_W'(NUM_CLASSES - 1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_HI = ACC_WIDTH'((1 << (W-1)) - 1);
  // Bitwise inverse of +2^(W-1)-1 is exactly -2^(W-1).
  localparam logic signed [ACC_WIDTH-1:0] SAT_LO = ~SAT_HI;

  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

  state_t state, state_nxt;

  logic [W*IN_SIZE-1:0]          x_reg;
  logic [IDX_W-1:0]              c;
  logic [K_W-1:0]                k;
  logic signed [ACC_WIDTH-1:0]   acc;
  logic signed [W-1:0]           run_max;
  logic [IDX_W-1:0]              run_idx;

  logic                          accept;
  logic                          last_k;
  logic                          last_step;
  logic [IDX_W-1:0]              c_inc;
  logic [IDX_W-1:0]              bias_idx;
  logic signed [W-1:0]           bias_sel;
  logic signed [ACC_WIDTH-1:0]   bias_ext;
  logic signed [W-1:0]           x_k;
  logic signed [W-1:0]           w_ck;
  logic signed [2*W-1:0]         prod;
  logic signed [ACC_WIDTH-1:0]   sum;
  logic signed [W-1:0]           sat;
  logic                          upd;
  logic signed [W-1:0]           max_nxt;
  logic [IDX_W-1:0]              idx_nxt;

  // ---------------- FSM: state register ----------------
  // NOTE: every clocked process uses non-blocking (<=) assignments so all
  // registers update together from values sampled at the same edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // ---------------- FSM: next-state logic ----------------
  // NOTE: defaulting every always_comb output first guarantees no path
  // leaves it unassigned, so no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start)     state_nxt = MAC;
      MAC:        if (last_step) state_nxt = DONE;
      default:                   state_nxt = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    busy = (state == MAC);
    done = (state == DONE);
  end

  // ---------------- datapath ----------------
  always_comb begin
    accept    = start && (state == IDLE || state == DONE);
    last_k    = (k == K_LAST);
    last_step = (state == MAC) && last_k && (c == C_LAST);
    c_inc     = c + 1'b1;
    // A new run starts from bias[0]; a class boundary loads the next bias.
    bias_idx  = accept ? '0 : c_inc;
    bias_sel  = biases_flat[int'(bias_idx)*W +: W];
    bias_ext  = {{(ACC_WIDTH-W){bias_sel[W-1]}}, bias_sel};

    x_k  = x_reg[int'(k)*W +: W];
    w_ck = weights_flat[(int'(c)*IN_SIZE + int'(k))*W +: W];
    prod = x_k * w_ck;
    sum  = acc + {{(ACC_WIDTH-2*W){prod[2*W-1]}}, prod};

    if (sum > SAT_HI)      sat = SAT_HI[W-1:0];
    else if (sum < SAT_LO) sat = SAT_LO[W-1:0];
    else                   sat = sum[W-1:0];

    // Strictly-greater replacement keeps the lowest index on ties.
    upd     = (c == '0) || (sat > run_max);
    max_nxt = upd ? sat : run_max;
    idx_nxt = upd ? c   : run_idx;
  end

  // NOTE: the logit register bank is reset along with the rest of the state,
  // so an aborted run leaves no partial results visible on logits_flat.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_reg       <= '0;
      c           <= '0;
      k           <= '0;
      acc         <= '0;
      run_max     <= '0;
      run_idx     <= '0;
      logits_flat <= '0;
      class_idx   <= '0;
      max_logit   <= '0;
    end else if (accept) begin
      x_reg <= in_vector_flat;
      c     <= '0;
      k     <= '0;
      acc   <= bias_ext;
    end else if (state == MAC) begin
      if (!last_k) begin
        acc <= sum;
        k   <= k + 1'b1;
      end else begin
        logits_flat[int'(c)*W +: W] <= sat;
        run_max <= max_nxt;
        run_idx <= idx_nxt;
        if (c != C_LAST) begin
          c   <= c_inc;
          k   <= '0;
          acc <= bias_ext;
        end else begin
          class_idx <= idx_nxt;
          max_logit <= max_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_fc_layer2_argmax.sv
// Directed testbench for fc_layer2_argmax (default parameters).
module tb_fc_layer2_argmax;

  localparam int IN  = 8;
  localparam int NC  = 10;
  localparam int W   = 8;
  localparam int LAT = NC * IN;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              start;
  logic [W*IN-1:0]   in_vector_flat;
  logic [W*NC*IN-1:0] weights_flat;
  logic [W*NC-1:0]   biases_flat;
  logic [W*NC-1:0]   logits_flat;
  logic [3:0]        class_idx;
  logic [W-1:0]      max_logit;
  logic              busy;
  logic              done;

  int n_vec = 0;
  int n_err = 0;
  logic signed [W-1:0] exp_l [NC];

  fc_layer2_argmax dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .in_vector_flat (in_vector_flat),
    .weights_flat   (weights_flat),
    .biases_flat    (biases_flat),
    .logits_flat    (logits_flat),
    .class_idx      (class_idx),
    .max_logit      (max_logit),
    .busy           (busy),
    .done           (done)
  );

  always #5 clk = ~clk;

  // ---------------- stimulus helpers (no comparisons) ----------------
  task automatic set_x_all(input int v);
    for (int k = 0; k < IN; k++) in_vector_flat[k*W +: W] = 8'(v);
  endtask

  task automatic set_w_all(input int v);
    for (int i = 0; i < NC*IN; i++) weights_flat[i*W +: W] = 8'(v);
  endtask

  task automatic set_w_class(input int c, input int v);
    for (int k = 0; k < IN; k++) weights_flat[(c*IN+k)*W +: W] = 8'(v);
  endtask

  task automatic set_b(input int c, input int v);
    biases_flat[c*W +: W] = 8'(v);
  endtask

  // Raise start for one edge (T0); returns 1 time unit after T0.
  task automatic start_op();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Counts edges after T0 until done is seen (bounded); records any cycle
  // where busy dropped before done.
  task automatic wait_done(output int cyc, output bit busy_ok);
    busy_ok = 1'b1;
    cyc = 0;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk);
      #1;
      cyc = i;
      if (done) break;
      if (!busy) busy_ok = 1'b0;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    start   = 1'b0;
    set_x_all(0); set_w_all(0);
    biases_flat = '0;
    #3;
    n_vec++;
    if (logits_flat !== '0 || class_idx !== 4'd0 || max_logit !== 8'd0 ||
        busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_async: logits=%h idx=%0d max=%0d busy=%b done=%b, required all 0",
               logits_flat, class_idx, max_logit, busy, done);
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    n_vec++;
    if (logits_flat !== '0 || class_idx !== 4'd0 || max_logit !== 8'd0 ||
        busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_idle: logits=%h idx=%0d max=%0d busy=%b done=%b, required all 0",
               logits_flat, class_idx, max_logit, busy, done);
    end
  endtask

  task automatic test_bias_only();
    int cyc; bit bok;
    set_x_all(10); set_w_all(0);
    for (int c = 0; c < NC; c++) begin set_b(c, c); exp_l[c] = 8'(c); end
    start_op();
    n_vec++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      n_err++;
      $display("FAIL bias_accept: busy=%b done=%b, required busy=1 done=0", busy, done);
    end
    wait_done(cyc, bok);
    n_vec++;
    if (cyc !== LAT) begin
      n_err++;
      $display("FAIL bias_latency: done after %0d cycles, required %0d", cyc, LAT);
    end
    n_vec++;
    if (!bok || busy !== 1'b0) begin
      n_err++;
      $display("FAIL bias_busy: busy_held=%b busy_at_done=%b, required 1/0", bok, busy);
    end
    for (int c = 0; c < NC; c++) begin
      n_vec++;
      if ($signed(logits_flat[c*W +: W]) !== exp_l[c]) begin
        n_err++;
        $display("FAIL bias_logit%0d: got %0d required %0d", c,
                 $signed(logits_flat[c*W +: W]), exp_l[c]);
      end
    end
    n_vec++;
    if (class_idx !== 4'd9 || max_logit !== 8'd9) begin
      n_err++;
      $display("FAIL bias_argmax: idx=%0d max=%0d, required idx=9 max=9",
               class_idx, $signed(max_logit));
    end
  endtask

  task automatic load_saturation();
    set_x_all(127); set_w_all(0);
    biases_flat = '0;
    set_w_class(3, 127);
    set_w_class(5, -128);
    for (int c = 0; c < NC; c++) exp_l[c] = 8'sd0;
    exp_l[3] = 8'sd127;
    exp_l[5] = -8'sd128;
  endtask

  task automatic test_saturation();
    int cyc; bit bok;
    load_saturation();
    start_op();
    wait_done(cyc, bok);
    n_vec++;
    if (cyc !== LAT) begin
      n_err++;
      $display("FAIL sat_latency: done after %0d cycles, required %0d", cyc, LAT);
    end
    for (int c = 0; c < NC; c++) begin
      n_vec++;
      if ($signed(logits_flat[c*W +: W]) !== exp_l[c]) begin
        n_err++;
        $display("FAIL sat_logit%0d: got %0d required %0d", c,
                 $signed(logits_flat[c*W +: W]), exp_l[c]);
      end
    end
    n_vec++;
    if (class_idx !== 4'd3 || max_logit !== 8'd127) begin
      n_err++;
      $display("FAIL sat_argmax: idx=%0d max=%0d, required idx=3 max=127",
               class_idx, $signed(max_logit));
    end
  endtask

  task automatic test_tie_negative();
    int cyc; bit bok;
    set_x_all(50); set_w_all(0);
    for (int c = 0; c < NC; c++) begin set_b(c, -7); exp_l[c] = -8'sd7; end
    set_b(4, 5); set_b(7, 5);
    exp_l[4] = 8'sd5; exp_l[7] = 8'sd5;
    start_op();
    wait_done(cyc, bok);
    for (int c = 0; c < NC; c++) begin
      n_vec++;
      if ($signed(logits_flat[c*W +: W]) !== exp_l[c]) begin
        n_err++;
        $display("FAIL tie_logit%0d: got %0d required %0d", c,
                 $signed(logits_flat[c*W +: W]), exp_l[c]);
      end
    end
    n_vec++;
    if (class_idx !== 4'd4 || max_logit !== 8'd5) begin
      n_err++;
      $display("FAIL tie_argmax: idx=%0d max=%0d, required idx=4 max=5",
               class_idx, $signed(max_logit));
    end
  endtask

  // Class 6 weights are 1, others 0: logit6 = sum(x), all other logits 0.
  task automatic test_handshake();
    int cyc; bit bok;
    set_w_all(0); set_w_class(6, 1);
    biases_flat = '0;
    for (int k = 0; k < IN; k++) in_vector_flat[k*W +: W] = 8'(k + 1);  // sum 36
    start_op();
    cyc = 0;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk);
      #1;
      cyc = i;
      if (done) break;
      if (i == 1)  set_x_all(-1);
      if (i == 30) start = 1'b1;
      if (i == 31) start = 1'b0;
    end
    start = 1'b0;
    n_vec++;
    if (cyc !== LAT) begin
      n_err++;
      $display("FAIL hs_latency: done after %0d cycles, required %0d", cyc, LAT);
    end
    n_vec++;
    if (class_idx !== 4'd6 || max_logit !== 8'd36 ||
        $signed(logits_flat[6*W +: W]) !== 8'sd36) begin
      n_err++;
      $display("FAIL hs_result: idx=%0d max=%0d logit6=%0d, required 6/36/36",
               class_idx, $signed(max_logit), $signed(logits_flat[6*W +: W]));
    end
    // Back-to-back: start while in DONE, new vector sums to 16.
    set_x_all(2);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n_vec++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_accept: busy=%b done=%b, required busy=1 done=0", busy, done);
    end
    n_vec++;
    if (max_logit !== 8'd36 || class_idx !== 4'd6) begin
      n_err++;
      $display("FAIL b2b_hold: idx=%0d max=%0d, required old 6/36 until completion",
               class_idx, $signed(max_logit));
    end
    wait_done(cyc, bok);
    n_vec++;
    if (cyc !== LAT || !bok) begin
      n_err++;
      $display("FAIL b2b_latency: done after %0d cycles busy_held=%b, required %0d/1",
               cyc, bok, LAT);
    end
    n_vec++;
    if (class_idx !== 4'd6 || max_logit !== 8'd16) begin
      n_err++;
      $display("FAIL b2b_result: idx=%0d max=%0d, required idx=6 max=16",
               class_idx, $signed(max_logit));
    end
  endtask

  task automatic test_mid_reset();
    int cyc; bit bok;
    set_x_all(10); set_w_all(0);
    for (int c = 0; c < NC; c++) set_b(c, c);
    start_op();
    repeat (39) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    n_vec++;
    if (logits_flat !== '0 || class_idx !== 4'd0 || max_logit !== 8'd0 ||
        busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL midrst_clear: logits=%h idx=%0d max=%0d busy=%b done=%b, required all 0",
               logits_flat, class_idx, max_logit, busy, done);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (busy !== 1'b0 || done !== 1'b0 || logits_flat !== '0) begin
      n_err++;
      $display("FAIL midrst_idle: busy=%b done=%b logits=%h, required idle and 0",
               busy, done, logits_flat);
    end
    load_saturation();
    start_op();
    wait_done(cyc, bok);
    n_vec++;
    if (cyc !== LAT || !bok) begin
      n_err++;
      $display("FAIL midrst_latency: done after %0d cycles busy_held=%b, required %0d/1",
               cyc, bok, LAT);
    end
    n_vec++;
    if (class_idx !== 4'd3 || max_logit !== 8'd127 ||
        $signed(logits_flat[5*W +: W]) !== -8'sd128) begin
      n_err++;
      $display("FAIL midrst_result: idx=%0d max=%0d logit5=%0d, required 3/127/-128",
               class_idx, $signed(max_logit), $signed(logits_flat[5*W +: W]));
    end
  endtask

  initial begin
    test_reset();
    test_bias_only();
    test_saturation();
    test_tie_negative();
    test_handshake();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
